// File: rtl/vga_pkg.sv
// Shared VGA types, timing helpers and colour-bar table for the frame streamer.
// The bar table is only consumed when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    logic [10:0] active;
    logic [10:0] fp;
    logic [10:0] sync;
    logic [10:0] bp;
  } timing_t;

  function automatic int total_period(input timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [0:7][23:0] BAR_TABLE = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with polarity-free sync, active and wrap flags.
// Flags are decoded from the current count; consumers register them.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter timing_t H_T = '{active: 11'd640, fp: 11'd16, sync: 11'd96, bp: 11'd48},
  parameter timing_t V_T = '{active: 11'd480, fp: 11'd10, sync: 11'd2, bp: 11'd33}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pix_en,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_line_end,
  output logic       o_frame_end
);

  localparam logic [9:0] H_LAST = 10'(total_period(H_T) - 1);
  localparam logic [9:0] V_LAST = 10'(total_period(V_T) - 1);
  localparam logic [9:0] H_ACT  = 10'(H_T.active);
  localparam logic [9:0] V_ACT  = 10'(V_T.active);
  localparam logic [9:0] H_S0   = 10'(int'(H_T.active) + int'(H_T.fp));
  localparam logic [9:0] H_S1   = 10'(int'(H_T.active) + int'(H_T.fp) + int'(H_T.sync));
  localparam logic [9:0] V_S0   = 10'(int'(V_T.active) + int'(V_T.fp));
  localparam logic [9:0] V_S1   = 10'(int'(V_T.active) + int'(V_T.fp) + int'(V_T.sync));

  logic [9:0] r_h;
  logic [9:0] r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (i_pix_en) begin
      if (r_h == H_LAST) begin
        r_h <= 10'd0;
        r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_hsync     = (r_h >= H_S0) && (r_h < H_S1);
  assign o_vsync     = (r_v >= V_S0) && (r_v < V_S1);
  assign o_active    = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_line_end  = (r_h == H_LAST);
  assign o_frame_end = (r_h == H_LAST) && (r_v == V_LAST);

endmodule

// File: rtl/vga_frame_streamer.sv
// VGA timing plus scaled grayscale framebuffer streamer with latency-matched sync/blank.
// Define VGA_TEST_PATTERN_EN to show colour bars instead of BORDER when disabled.
module vga_frame_streamer
  import vga_pkg::*;
#(
  parameter int     HACTIVE    = 640,
  parameter int     HFP        = 16,
  parameter int     HSYN       = 96,
  parameter int     HBP        = 48,
  parameter int     VACTIVE    = 480,
  parameter int     VFP        = 10,
  parameter int     VSYN       = 2,
  parameter int     VBP        = 33,
  parameter logic   SYNC_POL   = 1'b0,
  parameter int     IMG_W      = 256,
  parameter int     IMG_H      = 256,
  parameter int     SCALE_LOG2 = 0,
  parameter int     IMG_X0     = 192,
  parameter int     IMG_Y0     = 112,
  parameter int     RD_LAT     = 2,
  parameter pixel_t BORDER     = 8'h20,
  parameter int     AW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          enable,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          sync_n,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          frame_start,
  output logic [9:0]    x,
  output logic [9:0]    y
);

  localparam timing_t H_T = '{active: 11'(HACTIVE), fp: 11'(HFP), sync: 11'(HSYN), bp: 11'(HBP)};
  localparam timing_t V_T = '{active: 11'(VACTIVE), fp: 11'(VFP), sync: 11'(VSYN), bp: 11'(VBP)};
  localparam int WIN_X1   = IMG_X0 + (IMG_W << SCALE_LOG2);
  localparam int WIN_Y1   = IMG_Y0 + (IMG_H << SCALE_LOG2);
  localparam int REP_MASK = (1 << SCALE_LOG2) - 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       win;
`ifdef VGA_TEST_PATTERN_EN
    logic       bar_en;
    logic [2:0] bar;
`endif
    logic [9:0] x;
    logic [9:0] y;
  } stage_t;

  logic [9:0]    w_h;
  logic [9:0]    w_v;
  logic          w_hs;
  logic          w_vs;
  logic          w_act;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_win;
  logic          w_row_adv;
  logic [AW-1:0] w_addr;
  stage_t        w_stage;
  stage_t        w_out;

  logic          r_en;
  logic [AW-1:0] r_row_base;
  logic          r_rd;
  logic [AW-1:0] r_addr;
  logic          r_fs;
  stage_t        r_pipe [0:RD_LAT];

  vga_sync_counter #(.H_T(H_T), .V_T(V_T)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_pix_en   (pix_en),
    .o_h        (w_h),
    .o_v        (w_v),
    .o_hsync    (w_hs),
    .o_vsync    (w_vs),
    .o_active   (w_act),
    .o_line_end (w_line_end),
    .o_frame_end(w_frame_end)
  );

  // Window decode and address; row_base advances after the last replica of each image row.
  always_comb begin
    w_in_x    = (int'(w_h) >= IMG_X0) && (int'(w_h) < WIN_X1);
    w_in_y    = (int'(w_v) >= IMG_Y0) && (int'(w_v) < WIN_Y1);
    w_win     = w_act && r_en && w_in_x && w_in_y;
    w_row_adv = w_line_end && w_in_y && (((int'(w_v) - IMG_Y0) & REP_MASK) == REP_MASK);
    w_addr    = r_row_base + AW'((int'(w_h) - IMG_X0) >> SCALE_LOG2);
    w_stage   = '0;
    w_stage.hs  = w_hs;
    w_stage.vs  = w_vs;
    w_stage.act = w_act;
    w_stage.win = w_win;
    w_stage.x   = w_h;
    w_stage.y   = w_v;
`ifdef VGA_TEST_PATTERN_EN
    w_stage.bar_en = w_act && !r_en;
    w_stage.bar    = 3'(int'(w_h) / (HACTIVE / 8));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= enable;
      r_row_base <= '0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_fs       <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_fs <= 1'b0;
      if (pix_en) begin
        if (w_frame_end) begin
          r_en       <= enable;
          r_row_base <= '0;
        end else if (w_row_adv) begin
          r_row_base <= r_row_base + AW'(IMG_W);
        end
        r_rd      <= w_win;
        r_addr    <= w_win ? w_addr : '0;
        r_pipe[0] <= w_stage;
        for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        // Pulse in the cycle the output stage takes over the origin pixel.
        r_fs <= r_pipe[RD_LAT-1].act && (r_pipe[RD_LAT-1].x == 10'd0) &&
                (r_pipe[RD_LAT-1].y == 10'd0);
      end
    end
  end

  assign w_out       = r_pipe[RD_LAT];
  assign mem_rd      = r_rd;
  assign mem_addr    = r_addr;
  assign hsync       = w_out.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = w_out.vs ? SYNC_POL : ~SYNC_POL;
  assign blank_n     = w_out.act;
  assign sync_n      = ~(w_out.hs | w_out.vs);
  assign frame_start = r_fs;
  assign x           = w_out.x;
  assign y           = w_out.y;

  // mem_data arrives aligned with the last stage, so colour is selected directly from it.
  always_comb begin
    {red, green, blue} = 24'h000000;
    if (!w_out.act) begin
      {red, green, blue} = 24'h000000;
    end else if (w_out.win) begin
      {red, green, blue} = {3{mem_data}};
`ifdef VGA_TEST_PATTERN_EN
    end else if (w_out.bar_en) begin
      {red, green, blue} = BAR_TABLE[w_out.bar];
`endif
    end else begin
      {red, green, blue} = {3{BORDER}};
    end
  end

endmodule

// File: doc/vga_frame_streamer.md
Name: vga_frame_streamer

Overview:
- Parametrised VGA timing generator plus grayscale framebuffer streamer for the histogram-equalisation display path.
- Generates horizontal and vertical sync, blank and pixel coordinates from a single system clock with a pixel-rate enable.
- Fetches pixels of an IMG_W x IMG_H image, replicated by SCALE and placed at a programmable origin, from a fixed-latency read port.
- Drives 8-bit R/G/B with sync and blank delayed to stay aligned with the fetched data.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYN, 96, hsync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VACTIVE, 480, visible lines
- VFP, 10, vertical front porch (lines)
- VSYN, 2, vsync width (lines)
- VBP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- IMG_W, 256, image width (pixels)
- IMG_H, 256, image height (pixels)
- SCALE_LOG2, 0, pixel replication factor 2^SCALE_LOG2 (0..2)
- IMG_X0, 192, window left edge (screen pixels)
- IMG_Y0, 112, window top edge (screen lines)
- RD_LAT, 2, framebuffer read latency (pix_en ticks, 1..4)
- BORDER, 8'h20, gray level shown outside the window
- AW, 16, address width; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel-rate enable (e.g. one 25 MHz tick per 2 clocks at 50 MHz)
- enable  in  1  1 = stream image; 0 = show BORDER over the whole active area
- mem_rd  out  1  read strobe, one per fetched pixel
- mem_addr  out  AW  framebuffer address, row-major
- mem_data  in  8  gray pixel, valid RD_LAT pix_en ticks after mem_rd
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- blank_n  out  1  high during active video
- sync_n  out  1  composite sync (low when hsync or vsync is asserted)
- red, green, blue  out  8 each  pixel colour
- frame_start  out  1  one-clock pulse when the first active pixel is output
- x, y  out  10 each  screen coordinate of the pixel currently on red/green/blue

Behaviour:
- Reset values (held while rst=1): h_cnt=v_cnt=0, hsync=vsync=~SYNC_POL, sync_n=1, blank_n=0, RGB=0, mem_rd=0, mem_addr=0, frame_start=0, x=y=0, all pipeline stages cleared.
- Reset asserted mid-frame aborts the frame; the next frame starts from h=0, v=0.
- Counters advance only on pix_en. h_cnt wraps at H_TOTAL=HACTIVE+HFP+HSYN+HBP (800 by default).
- v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL (525 by default).
- Active region: h_cnt<HACTIVE and v_cnt<VACTIVE.
- hsync asserted for h_cnt in [HACTIVE+HFP, HACTIVE+HFP+HSYN). vsync uses the same rule on lines.
- Window condition:
  - IMG_X0 <= h < IMG_X0+(IMG_W<<SCALE_LOG2)
  - IMG_Y0 <= v < IMG_Y0+(IMG_H<<SCALE_LOG2)
  - active region, and enable=1
- Address generation (no multiplier):
  - mem_addr = row_base + ((h-IMG_X0)>>SCALE_LOG2).
  - row_base is cleared at frame start.
  - row_base += IMG_W after the last window line of each replicated group of 2^SCALE_LOG2 lines.
- mem_rd=1 on the window tick, registered (stage 0). One read is issued per screen pixel, including repeated reads of replicated pixels.
- Pipeline: hsync, vsync, blank, window flag, x and y are delayed RD_LAT+1 pix_en ticks so they align with mem_data.
- Output colour: R=G=B=mem_data when the delayed window flag is set; BORDER inside active area otherwise; 0 when blanked.
- The pipeline advances only on pix_en; outputs hold between ticks.
- Total latency from counter to pins is RD_LAT+1 pixel ticks, constant for every pixel.
- enable changes take effect at the next frame boundary only (latched when v_cnt wraps); a mid-frame toggle has no visible effect until then.
- frame_start pulses for exactly one clk on the pix_en tick when the aligned output is at x=0, y=0.
- A window exceeding the active area is clipped; mem_addr never exceeds IMG_W*IMG_H-1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined: enable=0 shows 8 vertical colour bars (HACTIVE/8 wide each: white, yellow, cyan, green, magenta, red, blue, black) instead of BORDER. No reads are issued. The bars use the same pipeline delay.
- When undefined: enable=0 shows BORDER. No bar logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - timing struct typedef (active/fp/sync/bp per axis)
  - localparam function for total period
  - colour-bar constant table
  - pixel_t (8-bit) typedef
- Sub-module vga_sync_counter: h/v counters, sync, active and frame-wrap flags from timing parameters. Reused by future overlay blocks.

Test Plan:
- Defaults, 2 frames, pix_en every 2nd clk -> hsync low 96 ticks per 800; vsync low 2 lines per 525; 640x480 blank_n-high ticks per frame.
- Model memory with data = addr[7:0] -> pixel at screen (192,112) has gray 0x00, at (193,112) 0x01, at (192,113) 0x00. (192,113) is line 1 of the image: address 256, low byte 0x00.
- SCALE_LOG2=1, IMG_X0=IMG_Y0=0 -> pixels (0,0),(1,0),(0,1),(1,1) all show address 0; (2,0) shows address 1; (0,2) shows address 256.
- RD_LAT=4 vs RD_LAT=1 -> the first window pixel appears on the same (x,y) coordinate in both runs; sync edges shift by the latency difference only.
- enable dropped at line 200 -> rest of frame unchanged; next frame shows BORDER 0x20 everywhere active; mem_rd stays 0.
- rst asserted for 1 clk at h=300, v=100 -> next clk shows all outputs at reset values; frame_start pulses (RD_LAT+1) pix_en ticks after rst release.
